// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data memory between the MEM
// pipeline stage and an external loader/debug port. The pipeline normally
// has priority. With ARB_STARVE_GUARD_EN defined, a starvation counter
// forces an external slot after STARVE_LIMIT consecutive refused cycles.
// Without the macro, the external port only gets cycles the pipeline leaves idle.
module data_mem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 8,
    parameter int DW           = 8
) (
    input  logic          Clkk,
    input  logic          Rst,
    input  logic          pipe_en,
    input  logic          pipe_rw,
    input  logic [AW-1:0] pipe_addr,
    input  logic [DW-1:0] pipe_wdata,
    input  logic          ext_req,
    input  logic          ext_rw,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          mem_en,
    output logic          mem_rw,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          pipe_stall,
    output logic [DW-1:0] pipe_rdata,
    output logic          pipe_rvalid,
    output logic          ext_gnt,
    output logic          ext_done,
    output logic [DW-1:0] ext_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PIPE = 2'd1,
        OWN_EXT  = 2'd2
    } owner_t;

    owner_t        r_owner;
    owner_t        w_owner_nxt;
    logic          r_rd;
    logic          w_rd_nxt;
    logic          w_pipe_win;
    logic          w_ext_win;
    logic          w_starved;
    logic [DW-1:0] r_pipe_rdata;
    logic [DW-1:0] r_ext_rdata;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    logic [CW-1:0] r_starve_cnt;

    assign w_starved = (r_starve_cnt == CW'(STARVE_LIMIT));

    // Starvation counter: counts refused ext cycles, cleared on grant or withdrawal.
    always_ff @(posedge Clkk) begin
        if (Rst) begin
            r_starve_cnt <= CW'(0);
        end else if (!ext_req || w_ext_win) begin
            r_starve_cnt <= CW'(0);
        end else if (!w_starved) begin
            r_starve_cnt <= r_starve_cnt + CW'(1);
        end else begin
            r_starve_cnt <= r_starve_cnt;
        end
    end
`else
    assign w_starved = 1'b0;
`endif

    // Arbitration: pick at most one winner this cycle; nobody wins during reset.
    always_comb begin
        w_ext_win  = 1'b0;
        w_pipe_win = 1'b0;
        if (Rst) begin
            w_ext_win  = 1'b0;
            w_pipe_win = 1'b0;
        end else begin
            w_ext_win  = ext_req && (!pipe_en || w_starved);
            w_pipe_win = pipe_en && !w_ext_win;
        end
    end

    // Memory drive and requester handshakes follow the winner; idle bus is all zero.
    always_comb begin
        mem_en     = 1'b0;
        mem_rw     = 1'b0;
        mem_addr   = {AW{1'b0}};
        mem_wdata  = {DW{1'b0}};
        ext_gnt    = w_ext_win;
        pipe_stall = w_ext_win && pipe_en;
        if (w_pipe_win) begin
            mem_en    = 1'b1;
            mem_rw    = pipe_rw;
            mem_addr  = pipe_addr;
            mem_wdata = pipe_wdata;
        end else if (w_ext_win) begin
            mem_en    = 1'b1;
            mem_rw    = ext_rw;
            mem_addr  = ext_addr;
            mem_wdata = ext_wdata;
        end else begin
            mem_en    = 1'b0;
        end
    end

    // Owner next-state: the owner of the following cycle is this cycle's winner.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        w_rd_nxt    = 1'b0;
        if (w_pipe_win) begin
            w_owner_nxt = OWN_PIPE;
            w_rd_nxt    = !pipe_rw;
        end else if (w_ext_win) begin
            w_owner_nxt = OWN_EXT;
            w_rd_nxt    = !ext_rw;
        end else begin
            w_owner_nxt = OWN_NONE;
            w_rd_nxt    = 1'b0;
        end
    end

    // Owner state register; reset drops any access still in flight.
    always_ff @(posedge Clkk) begin
        if (Rst) begin
            r_owner <= OWN_NONE;
            r_rd    <= 1'b0;
        end else begin
            r_owner <= w_owner_nxt;
            r_rd    <= w_rd_nxt;
        end
    end

    // Completion strobes for the access issued last cycle, suppressed during reset.
    always_comb begin
        pipe_rvalid = 1'b0;
        ext_done    = 1'b0;
        case (r_owner)
            OWN_PIPE: pipe_rvalid = r_rd && !Rst;
            OWN_EXT:  ext_done    = !Rst;
            OWN_NONE: pipe_rvalid = 1'b0;
            default:  pipe_rvalid = 1'b0;
        endcase
    end

    // Capture returning read data for whichever requester owns the memory.
    always_ff @(posedge Clkk) begin
        if (Rst) begin
            r_pipe_rdata <= {DW{1'b0}};
            r_ext_rdata  <= {DW{1'b0}};
        end else begin
            if (r_owner == OWN_PIPE && r_rd) begin
                r_pipe_rdata <= mem_rdata;
            end else begin
                r_pipe_rdata <= r_pipe_rdata;
            end
            if (r_owner == OWN_EXT && r_rd) begin
                r_ext_rdata <= mem_rdata;
            end else begin
                r_ext_rdata <= r_ext_rdata;
            end
        end
    end

    assign pipe_rdata = r_pipe_rdata;
    assign ext_rdata  = r_ext_rdata;

endmodule
